// File: rtl/bit_serial.sv
// Bit-serial accumulator machine. Each instruction takes 10 cycles:
// FETCH (1), EXEC (8, one bit per cycle, LSB first) and DONE (1).
// The external program counter advances on the DONE pulse.
module bit_serial (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_data_instruction,
  input  logic [7:0] i_data_switch,
  input  logic       i_start,
  output logic       o_con_pcincr,
  output logic [7:0] o_data_display
);

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_LDB  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] a_reg, b_reg, s_reg, d_reg;
  logic [2:0] ir_reg, cnt_reg;
  logic       c_reg;

  logic       a_bit, b_bit, b_eff, s_bit;
  logic       a_in, b_in, c_next;
  logic [7:0] a_next, b_next;

  // Right shift with the new result bit entering at the MSB.
  assign a_next[7] = a_in;
  assign b_next[7] = b_in;
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_shift
      assign a_next[gi] = a_reg[gi+1];
      assign b_next[gi] = b_reg[gi+1];
    end
  endgenerate

  // Next-state logic: EXEC runs until the bit counter reaches 7.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    if (cnt_reg == 3'd7) state_next = DONE;
      DONE:    state_next = (ir_reg == OP_HALT) ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // One-bit ALU slice; SUB reuses the adder with B inverted and carry-in 1.
  always_comb begin
    a_bit  = a_reg[0];
    b_bit  = b_reg[0];
    s_bit  = s_reg[cnt_reg];
    b_eff  = (ir_reg == OP_SUB) ? ~b_bit : b_bit;
    a_in   = a_bit;
    b_in   = b_bit;
    c_next = c_reg;
    case (ir_reg)
      OP_LDA: a_in = s_bit;
      OP_LDB: b_in = s_bit;
      OP_ADD, OP_SUB: begin
        a_in   = a_bit ^ b_eff ^ c_reg;
        c_next = (a_bit & b_eff) | (a_bit & c_reg) | (b_eff & c_reg);
      end
      OP_AND: a_in = a_bit & b_bit;
      OP_XOR: a_in = a_bit ^ b_bit;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Datapath: capture operands in FETCH, shift one bit per EXEC cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      s_reg   <= 8'h00;
      d_reg   <= 8'h00;
      ir_reg  <= 3'd0;
      cnt_reg <= 3'd0;
      c_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          ir_reg  <= i_data_instruction;
          s_reg   <= i_data_switch;
          cnt_reg <= 3'd0;
          c_reg   <= (i_data_instruction == OP_SUB);
        end
        EXEC: begin
          a_reg   <= a_next;
          b_reg   <= b_next;
          c_reg   <= c_next;
          cnt_reg <= cnt_reg + 3'd1;
          // After the eighth rotation A is back in its original order.
          if (ir_reg == OP_OUT && cnt_reg == 3'd7) d_reg <= a_next;
        end
        default: ;
      endcase
    end
  end

  assign o_con_pcincr   = (state_reg == DONE);
  assign o_data_display = d_reg;

endmodule

// File: tb/tb_bit_serial.sv
// Directed bench for bit_serial with an instruction-level reference model.
module tb_bit_serial;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [2:0] i_data_instruction;
  logic [7:0] i_data_switch;
  logic       i_start;
  logic       o_con_pcincr;
  logic [7:0] o_data_display;

  bit_serial dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_data_instruction (i_data_instruction),
    .i_data_switch      (i_data_switch),
    .i_start            (i_start),
    .o_con_pcincr       (o_con_pcincr),
    .o_data_display     (o_data_display)
  );

  always #5 i_clk = ~i_clk;

  // External program memory and program counter.
  logic [2:0] prog_op [16];
  logic [7:0] prog_sw [16];
  logic [3:0] pc;
  logic       sw_ovr_en;
  logic [7:0] sw_ovr;

  assign i_data_instruction = prog_op[pc];
  assign i_data_switch      = sw_ovr_en ? sw_ovr : prog_sw[pc];

  always @(posedge i_clk) begin
    if (i_rst)             pc <= 4'd0;
    else if (o_con_pcincr) pc <= pc + 4'd1;
  end

  // Reference model: position within the 10-cycle instruction (0 = idle,
  // 1 = fetch, 10 = the pc-increment cycle) and the architectural results.
  int         m_k;
  logic [2:0] m_ir;
  logic [7:0] m_sw, m_a, m_b, m_d;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int npulse;
  int pulse_at [8];
  logic [7:0] disp_hist [64];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_edge();
    if (i_rst) begin
      m_k = 0; m_a = 8'h00; m_b = 8'h00; m_d = 8'h00;
    end else if (m_k == 0) begin
      if (i_start) m_k = 1;
    end else if (m_k == 1) begin
      m_ir = i_data_instruction;
      m_sw = i_data_switch;
      m_k  = 2;
    end else if (m_k < 9) begin
      m_k++;
    end else if (m_k == 9) begin
      case (m_ir)
        3'b000: m_a = m_sw;
        3'b001: m_b = m_sw;
        3'b010: m_a = m_a + m_b;
        3'b011: m_a = m_a - m_b;
        3'b100: m_a = m_a & m_b;
        3'b101: m_a = m_a ^ m_b;
        3'b110: m_d = m_a;
        default: ;
      endcase
      m_k = 10;
    end else begin
      m_k = (m_ir == 3'b111) ? 0 : 1;
    end
  endtask

  // One clock: model update, then compare outputs on the falling edge.
  task automatic step();
    model_edge();
    @(negedge i_clk);
    cyc++;
    check("pcincr", {7'b0, o_con_pcincr}, {7'b0, (m_k == 10)});
    check("display", o_data_display, m_d);
    if (o_con_pcincr && npulse < 8) begin
      pulse_at[npulse] = cyc;
      npulse++;
    end
    if (cyc >= 0 && cyc < 64) disp_hist[cyc] = o_data_display;
  endtask

  task automatic do_reset();
    sw_ovr_en = 1'b0;
    sw_ovr    = 8'h00;
    i_start   = 1'b0;
    i_rst     = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog_op[i] = 3'b111;
      prog_sw[i] = 8'h00;
    end
  endtask

  task automatic begin_run(input logic hold);
    cyc = 0;
    npulse = 0;
    i_start = 1'b1;
    step();
    i_start = hold;
  endtask

  task automatic finish_run();
    for (int i = 0; i < 200 && m_k != 0; i++) step();
    check_int("run_reaches_idle", m_k, 0);
    repeat (3) step();
  endtask

  task automatic arith(input string name, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] want);
    clear_prog();
    prog_op[0] = 3'b000; prog_sw[0] = a;
    prog_op[1] = 3'b001; prog_sw[1] = b;
    prog_op[2] = op;
    prog_op[3] = 3'b110;
    prog_op[4] = 3'b111;
    do_reset();
    begin_run(1'b0);
    finish_run();
    check({name, "_model"}, m_d, want);
    check(name, o_data_display, want);
    check_int({name, "_pulses"}, npulse, 5);
  endtask

  initial begin
    clear_prog();
    cyc = 0;
    npulse = 0;
    i_start = 1'b0;
    sw_ovr_en = 1'b0;
    sw_ovr = 8'h00;
    i_rst = 1'b1;

    // Reset state, then 50 idle cycles with no start.
    do_reset();
    check("reset_display", o_data_display, 8'h00);
    cyc = 0; npulse = 0;
    repeat (50) step();
    check_int("idle_pulses", npulse, 0);
    check("idle_display", o_data_display, 8'h00);

    // LDA F0, OUT, HALT with a one-cycle start pulse.
    clear_prog();
    prog_op[0] = 3'b000; prog_sw[0] = 8'hF0;
    prog_op[1] = 3'b110;
    do_reset();
    begin_run(1'b0);
    finish_run();
    check_int("first_pulse", pulse_at[0], 10);
    check_int("second_pulse", pulse_at[1], 20);
    check_int("halt_pulse", pulse_at[2], 30);
    check("display_before_out", disp_hist[19], 8'h00);
    check("display_after_out", disp_hist[20], 8'hF0);

    // Arithmetic and logic programs.
    arith("add_3c_c5", 3'b010, 8'h3C, 8'hC5, 8'h01);
    arith("sub_05_07", 3'b011, 8'h05, 8'h07, 8'hFE);
    arith("and_f0_3c", 3'b100, 8'hF0, 8'h3C, 8'h30);
    arith("xor_f0_3c", 3'b101, 8'hF0, 8'h3C, 8'hCC);
    arith("add_ff_01", 3'b010, 8'hFF, 8'h01, 8'h00);

    // Reset during EXEC bit 4 of an OUT, after an earlier OUT set the display.
    clear_prog();
    prog_op[0] = 3'b000; prog_sw[0] = 8'h5A;
    prog_op[1] = 3'b110;
    prog_op[2] = 3'b000; prog_sw[2] = 8'hA5;
    prog_op[3] = 3'b110;
    do_reset();
    begin_run(1'b0);
    while (cyc < 36) step();
    check("display_pre_reset", o_data_display, 8'h5A);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("display_post_reset", o_data_display, 8'h00);
    check("pcincr_post_reset", {7'b0, o_con_pcincr}, 8'h00);
    npulse = 0;
    repeat (30) step();
    check_int("pulses_after_reset", npulse, 0);

    // Switch change and start re-pulse during EXEC of an LDA.
    clear_prog();
    prog_op[0] = 3'b000; prog_sw[0] = 8'h77;
    prog_op[1] = 3'b110;
    do_reset();
    begin_run(1'b0);
    while (cyc < 5) step();
    sw_ovr_en = 1'b1;
    sw_ovr = 8'h11;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    finish_run();
    sw_ovr_en = 1'b0;
    check_int("repulse_first", pulse_at[0], 10);
    check_int("repulse_second", pulse_at[1], 20);
    check("lda_captured_switch", o_data_display, 8'h77);
    check("lda_captured_model", m_d, 8'h77);

    // HALT with start held high: one idle cycle before the next fetch.
    clear_prog();
    prog_op[0] = 3'b000; prog_sw[0] = 8'h42;
    prog_op[1] = 3'b111;
    prog_op[2] = 3'b110;
    do_reset();
    begin_run(1'b1);
    while (cyc < 31) step();
    i_start = 1'b0;
    finish_run();
    check_int("held_start_p1", pulse_at[0], 10);
    check_int("held_start_p2", pulse_at[1], 20);
    check_int("held_start_p3", pulse_at[2], 31);
    check("held_start_display", disp_hist[31], 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
